// File: rtl/counter_game_param_if.sv
// Driver/observer bundle for the parametrised counter game.
// The master side drives the controls; the slave side (the game) drives the results.
interface counter_game_param_if #(
    parameter int WIDTH   = 4,
    parameter int SCORE_W = 4
);
    logic               en;
    logic [1:0]         control;
    logic               INIT;
    logic [WIDTH-1:0]   load_value;
    logic [WIDTH-1:0]   count_out;
    logic [SCORE_W-1:0] winner_count;
    logic [SCORE_W-1:0] loser_count;
    logic               WINNER;
    logic               LOSER;
    logic               GAMEOVER;
    logic [1:0]         WHO;

    modport master (
        output en, control, INIT, load_value,
        input  count_out, winner_count, loser_count, WINNER, LOSER, GAMEOVER, WHO
    );

    modport slave (
        input  en, control, INIT, load_value,
        output count_out, winner_count, loser_count, WINNER, LOSER, GAMEOVER, WHO
    );
endinterface

// File: rtl/counter_game_param.sv
// Parametrised up/down counter game: landing on all-ones scores a win,
// landing on zero scores a loss; the first score to reach WIN_LIMIT ends the game.
module counter_game_param #(
    parameter int WIDTH        = 4,
    parameter int SCORE_W      = 4,
    parameter int STEP_BIG     = 2,
    parameter int WIN_LIMIT    = 15,
    parameter int AUTO_RESTART = 0
) (
    input  logic clk,
    input  logic rst,
    counter_game_param_if.slave bus
);

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0]   MAX_VAL   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ZERO_VAL  = '0;
    localparam logic [WIDTH-1:0]   BIG_STEP  = WIDTH'(STEP_BIG);
    localparam logic [WIDTH-1:0]   UNIT_STEP = WIDTH'(1);
    localparam logic [SCORE_W-1:0] LIMIT     = SCORE_W'(WIN_LIMIT);
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
    localparam bit                 AUTO      = (AUTO_RESTART != 0);

    localparam logic [1:0] WHO_NONE = 2'b00;
    localparam logic [1:0] WHO_LOSS = 2'b01;
    localparam logic [1:0] WHO_WIN  = 2'b10;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [SCORE_W-1:0] win_q, win_d;
    logic [SCORE_W-1:0] lose_q, lose_d;
    logic               winner_q, winner_d;
    logic               loser_q, loser_d;
    logic [1:0]         who_q, who_d;

    logic [WIDTH-1:0]   step_mag;
    logic [WIDTH-1:0]   step_next;
    logic [SCORE_W-1:0] win_inc;
    logic [SCORE_W-1:0] lose_inc;

    // Wrap-around is free: the add/subtract is naturally modulo 2**WIDTH.
    always_comb begin
        step_mag  = bus.control[0] ? BIG_STEP : UNIT_STEP;
        step_next = bus.control[1] ? (count_q - step_mag) : (count_q + step_mag);
        win_inc   = win_q + SCORE_ONE;
        lose_inc  = lose_q + SCORE_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= PLAY;
            count_q  <= '0;
            win_q    <= '0;
            lose_q   <= '0;
            winner_q <= 1'b0;
            loser_q  <= 1'b0;
            who_q    <= WHO_NONE;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            win_q    <= win_d;
            lose_q   <= lose_d;
            winner_q <= winner_d;
            loser_q  <= loser_d;
            who_q    <= who_d;
        end
    end

    // INIT overrides whatever the game state would otherwise do on this edge.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        win_d    = win_q;
        lose_d   = lose_q;
        winner_d = 1'b0;
        loser_d  = 1'b0;
        who_d    = who_q;

        if (bus.INIT) begin
            state_d = PLAY;
            count_d = bus.load_value;
            win_d   = '0;
            lose_d  = '0;
            who_d   = WHO_NONE;
        end else begin
            unique case (state_q)
                PLAY: begin
                    if (bus.en) begin
                        count_d = step_next;
                        if (step_next == MAX_VAL) begin
                            winner_d = 1'b1;
                            win_d    = win_inc;
                            if (win_inc == LIMIT) begin
                                state_d = OVER;
                                who_d   = WHO_WIN;
                            end
                        end else if (step_next == ZERO_VAL) begin
                            loser_d = 1'b1;
                            lose_d  = lose_inc;
                            if (lose_inc == LIMIT) begin
                                state_d = OVER;
                                who_d   = WHO_LOSS;
                            end
                        end
                    end
                end
                OVER: begin
                    if (AUTO) begin
                        state_d = PLAY;
                        win_d   = '0;
                        lose_d  = '0;
                        who_d   = WHO_NONE;
                    end
                end
                default: state_d = PLAY;
            endcase
        end
    end

    assign bus.count_out    = count_q;
    assign bus.winner_count = win_q;
    assign bus.loser_count  = lose_q;
    assign bus.WINNER       = winner_q;
    assign bus.LOSER        = loser_q;
    assign bus.GAMEOVER     = (state_q == OVER);
    assign bus.WHO          = who_q;

endmodule

// File: tb/tb_counter_game_param.sv
// Scoreboard bench for counter_game_param: two instances (hold-on-over and auto-restart)
// share one stimulus stream and are each checked against a behavioural game model.
module tb_counter_game_param;

    localparam int WIDTH   = 4;
    localparam int SCORE_W = 4;
    localparam int LIMIT_A = 3;
    localparam int LIMIT_B = 2;

    typedef struct packed {
        logic [3:0] count;
        logic [3:0] win;
        logic [3:0] lose;
        logic       winner;
        logic       loser;
        logic       over;
        logic [1:0] who;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    counter_game_param_if #(.WIDTH(WIDTH), .SCORE_W(SCORE_W)) ifa ();
    counter_game_param_if #(.WIDTH(WIDTH), .SCORE_W(SCORE_W)) ifb ();

    counter_game_param #(
        .WIDTH(WIDTH), .SCORE_W(SCORE_W), .STEP_BIG(2),
        .WIN_LIMIT(LIMIT_A), .AUTO_RESTART(0)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(ifa)
    );

    counter_game_param #(
        .WIDTH(WIDTH), .SCORE_W(SCORE_W), .STEP_BIG(2),
        .WIN_LIMIT(LIMIT_B), .AUTO_RESTART(1)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(ifb)
    );

    always #5 clk = ~clk;

    obs_t qa[$];
    obs_t qb[$];
    obs_t model_a = '0;
    obs_t model_b = '0;
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;

    // Game rules in plain arithmetic: one call = one clock edge.
    function automatic obs_t model_next(obs_t m, int limit, bit auto_rs, bit r, bit init,
                                        bit en, logic [1:0] ctl, logic [3:0] load);
        obs_t n = m;
        int   d;
        int   c;
        n.winner = 1'b0;
        n.loser  = 1'b0;
        if (r) begin
            n = '0;
        end else if (init) begin
            n = '0;
            n.count = load;
        end else if (m.over) begin
            if (auto_rs) begin
                n.win  = 4'd0;
                n.lose = 4'd0;
                n.over = 1'b0;
                n.who  = 2'b00;
            end
        end else if (en) begin
            d = ctl[0] ? 2 : 1;
            if (ctl[1]) d = -d;
            c = (int'(m.count) + d + 16) % 16;
            n.count = 4'(c);
            if (c == 15) begin
                n.winner = 1'b1;
                n.win    = 4'(int'(m.win) + 1);
                if (int'(m.win) + 1 == limit) begin
                    n.over = 1'b1;
                    n.who  = 2'b10;
                end
            end else if (c == 0) begin
                n.loser = 1'b1;
                n.lose  = 4'(int'(m.lose) + 1);
                if (int'(m.lose) + 1 == limit) begin
                    n.over = 1'b1;
                    n.who  = 2'b01;
                end
            end
        end
        return n;
    endfunction

    task automatic applyStimulus(input bit r, input bit init, input bit en,
                                 input logic [1:0] ctl, input logic [3:0] load);
        @(negedge clk);
        rst            = r;
        ifa.INIT       = init;
        ifa.en         = en;
        ifa.control    = ctl;
        ifa.load_value = load;
        ifb.INIT       = init;
        ifb.en         = en;
        ifb.control    = ctl;
        ifb.load_value = load;
        model_a = model_next(model_a, LIMIT_A, 1'b0, r, init, en, ctl, load);
        model_b = model_next(model_b, LIMIT_B, 1'b1, r, init, en, ctl, load);
        qa.push_back(model_a);
        qb.push_back(model_b);
    endtask

    task automatic doStep(input logic [1:0] ctl);
        applyStimulus(1'b0, 1'b0, 1'b1, ctl, 4'd0);
    endtask

    task automatic doLoad(input logic [3:0] v);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, v);
    endtask

    task automatic doPause();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
    endtask

    task automatic checkOutput(input string name, input obs_t exp, input obs_t act);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s cycle %0d: got cnt=%0d win=%0d lose=%0d W=%b L=%b GO=%b WHO=%b, expected cnt=%0d win=%0d lose=%0d W=%b L=%b GO=%b WHO=%b",
                     name, cycle, act.count, act.win, act.lose, act.winner, act.loser, act.over, act.who,
                     exp.count, exp.win, exp.lose, exp.winner, exp.loser, exp.over, exp.who);
        end
    endtask

    function automatic obs_t sample_a();
        return '{ifa.count_out, ifa.winner_count, ifa.loser_count,
                 ifa.WINNER, ifa.LOSER, ifa.GAMEOVER, ifa.WHO};
    endfunction

    function automatic obs_t sample_b();
        return '{ifb.count_out, ifb.winner_count, ifb.loser_count,
                 ifb.WINNER, ifb.LOSER, ifb.GAMEOVER, ifb.WHO};
    endfunction

    // Monitor: every edge that follows issued stimulus yields one observation per DUT.
    always @(posedge clk) begin
        obs_t ea;
        obs_t eb;
        #1;
        cycle++;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            checkOutput("hold_dut", ea, sample_a());
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            checkOutput("auto_dut", eb, sample_b());
        end
    end

    initial begin
        ifa.INIT = 1'b0; ifa.en = 1'b0; ifa.control = 2'b00; ifa.load_value = 4'd0;
        ifb.INIT = 1'b0; ifb.en = 1'b0; ifb.control = 2'b00; ifb.load_value = 4'd0;

        // Reset wins over a simultaneous INIT and step.
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 4'd7);

        // Land on MAX, then pause there without re-scoring.
        doLoad(4'd14);
        doStep(2'b00);
        repeat (3) doPause();

        // Wrap in both directions.
        doLoad(4'd15);
        doStep(2'b00);
        doLoad(4'd1);
        doStep(2'b11);

        // Three wins end the hold game; auto game ends after two and restarts.
        doLoad(4'd13);
        doStep(2'b01);
        doStep(2'b10);
        doStep(2'b00);
        doStep(2'b10);
        doStep(2'b00);
        for (int i = 0; i < 10; i++) doStep(2'($urandom_range(0, 3)));
        doLoad(4'd5);

        // Two losses end the auto game, then play resumes from the held count.
        doLoad(4'd1);
        doStep(2'b10);
        doStep(2'b00);
        doStep(2'b10);
        doPause();
        doStep(2'b00);

        // INIT in the auto-restart cycle takes priority.
        doLoad(4'd1);
        doStep(2'b10);
        doStep(2'b00);
        doStep(2'b10);
        doLoad(4'd9);

        // Loading MAX alongside an enabled step never scores.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 4'd15);
        doPause();

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)));
        end

        doPause();
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
